// File: rtl/axis_dest_demux.sv
// Frame-aware AXI-stream demultiplexer: each frame is steered to the output chosen by the
// tdest of its first beat, and out-of-range frames are swallowed. Two-entry skid output stage.
module axis_dest_demux #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 64,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter bit ID_ENABLE   = 1,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter bit USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter bit LAST_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [M_COUNT-1:0]    m_axis_tvalid,
    input  logic [M_COUNT-1:0]    m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_drop
);

    localparam int SEL_WIDTH = $clog2(M_COUNT);

    typedef enum logic [1:0] {ST_IDLE, ST_ROUTE, ST_DROP} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
        logic [SEL_WIDTH-1:0]  port;
    } beat_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 in_last, accept, dest_in_range;
    logic                 route_valid;
    logic [SEL_WIDTH-1:0] route_port;
    beat_t                in_beat, out_q, temp_q;
    logic                 out_valid_q, temp_valid_q, s_ready_q;
    logic                 m_ready_sel, ready_early;

    // A beat transfers on any edge where its valid and ready are both high; valid never
    // waits on ready, and s_axis_tready depends only on registered state.
    assign in_last       = LAST_ENABLE ? s_axis_tlast : 1'b1;
    assign s_axis_tready = (state_q == ST_DROP) ? 1'b1 : s_ready_q;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign dest_in_range = {1'b0, s_axis_tdest} < (DEST_WIDTH + 1)'(M_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dest_in_range) begin
                        sel_d   = s_axis_tdest[SEL_WIDTH-1:0];
                        state_d = in_last ? ST_IDLE : ST_ROUTE;
                    end else begin
                        state_d = in_last ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_ROUTE, ST_DROP: begin
                if (accept && in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The frame's first beat is steered by its own tdest; later beats use the latched sel.
    always_comb begin
        route_valid = 1'b0;
        route_port  = sel_q;
        status_drop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                route_valid = accept && dest_in_range;
                route_port  = s_axis_tdest[SEL_WIDTH-1:0];
                status_drop = accept && !dest_in_range;
            end
            ST_ROUTE: route_valid = accept;
            default: ;
        endcase
    end

    always_comb begin
        in_beat      = '0;
        in_beat.data = s_axis_tdata;
        in_beat.keep = KEEP_ENABLE ? s_axis_tkeep : '1;
        in_beat.last = in_last;
        in_beat.id   = ID_ENABLE ? s_axis_tid : '0;
        in_beat.dest = s_axis_tdest;
        in_beat.user = USER_ENABLE ? s_axis_tuser : '0;
        in_beat.port = route_port;
    end

    assign m_ready_sel = m_axis_tready[out_q.port];
    assign ready_early = (out_valid_q && m_ready_sel) ||
                         (!temp_valid_q && (!out_valid_q || !route_valid));

    // While s_ready_q is high the temp register is empty, so a stalled output spills into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            temp_valid_q <= 1'b0;
            out_q        <= '0;
            temp_q       <= '0;
        end else begin
            s_ready_q <= ready_early;
            if (s_ready_q) begin
                if (m_ready_sel || !out_valid_q) begin
                    out_valid_q <= route_valid;
                    if (route_valid) out_q <= in_beat;
                end else begin
                    temp_valid_q <= route_valid;
                    if (route_valid) temp_q <= in_beat;
                end
            end else if (m_ready_sel || !out_valid_q) begin
                out_valid_q  <= temp_valid_q;
                if (temp_valid_q) out_q <= temp_q;
                temp_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_valid_q ? (M_COUNT'(1) << out_q.port) : '0;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = KEEP_ENABLE ? out_q.keep : '1;
    assign m_axis_tlast  = LAST_ENABLE ? out_q.last : 1'b1;
    assign m_axis_tid    = out_q.id;
    assign m_axis_tdest  = out_q.dest;
    assign m_axis_tuser  = out_q.user;

endmodule

// File: tb/tb_axis_dest_demux.sv
// Directed bench for axis_dest_demux: routing, drop, back-to-back frames, skid stall, reset.
module tb_axis_dest_demux;

    localparam int EXP_W = 4 + 8 + 8 + 1 + 64;

    logic        clk;
    logic        rst_n;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  s_axis_tid;
    logic [7:0]  s_axis_tdest;
    logic [0:0]  s_axis_tuser;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [3:0]  m_axis_tvalid;
    logic [3:0]  m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [7:0]  m_axis_tdest;
    logic [0:0]  m_axis_tuser;
    logic        status_drop;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int drop_cnt = 0;
    logic [EXP_W-1:0] exp_q[$];

    axis_dest_demux #(.M_COUNT(4), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .status_drop(status_drop)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] mk_exp(input logic [3:0] mask, input logic [7:0] dest,
                                                input logic last, input logic [63:0] data);
        return {mask, dest, data[7:0], last, data};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic send_beat(input logic [63:0] data, input logic [7:0] dest, input logic last,
                             input logic [3:0] exp_mask);
        bit done = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = last;
        s_axis_tid    = data[7:0];
        s_axis_tdest  = dest;
        s_axis_tuser  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                done = 1;
                break;
            end
        end
        if (done) begin
            @(posedge clk);
            #1;
            last_acc_cyc = cyc;
            if (exp_mask != 4'b0000) exp_q.push_back(mk_exp(exp_mask, dest, last, data));
        end else begin
            check_eq("accept_timeout", s_axis_tready, 1);
        end
    endtask

    task automatic s_idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed output transfer must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid != 4'b0000) check_eq("tvalid_onehot", $countones(m_axis_tvalid), 1);
            if ((m_axis_tvalid & m_axis_tready) != 4'b0000) begin
                check_eq("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check_eq("sb_beat", {m_axis_tvalid, m_axis_tdest, m_axis_tid, m_axis_tlast, m_axis_tdata},
                             exp_q.pop_front());
            end
            if (status_drop) drop_cnt++;
        end
    end

    initial begin
        int a0;
        int d0;
        rst_n = 1'b0;
        m_axis_tready = 4'b1111;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tid = '0;
        s_axis_tdest = '0; s_axis_tuser = '0;
        s_idle();

        // Reset state
        wait_cycles(3);
        check_eq("rst_tvalid", m_axis_tvalid, 4'b0000);
        check_eq("rst_tready", s_axis_tready, 0);
        check_eq("rst_drop", status_drop, 0);
        check_eq("rst_tdata", m_axis_tdata, 64'h0);
        check_eq("rst_tlast", m_axis_tlast, 0);
        rst_n = 1'b1;
        check_eq("tready_before_edge", s_axis_tready, 0);
        wait_cycles(1);
        check_eq("tready_after_edge", s_axis_tready, 1);

        // 3-beat frame to port 2, each beat visible right after its acceptance edge
        send_beat(64'h2000_0000_0000_0011, 8'd2, 1'b0, 4'b0100);
        check_eq("t1_valid0", m_axis_tvalid, 4'b0100);
        check_eq("t1_data0", m_axis_tdata, 64'h2000_0000_0000_0011);
        send_beat(64'h2000_0000_0000_0012, 8'd2, 1'b0, 4'b0100);
        check_eq("t1_valid1", m_axis_tvalid, 4'b0100);
        check_eq("t1_data1", m_axis_tdata, 64'h2000_0000_0000_0012);
        send_beat(64'h2000_0000_0000_0013, 8'd2, 1'b1, 4'b0100);
        check_eq("t1_valid2", m_axis_tvalid, 4'b0100);
        check_eq("t1_last2", m_axis_tlast, 1);
        s_idle();
        wait_cycles(2);

        // Back-to-back frames to ports 1 and 3: four accepts on consecutive edges
        send_beat(64'h1000_0000_0000_0021, 8'd1, 1'b0, 4'b0010);
        a0 = last_acc_cyc;
        send_beat(64'h1000_0000_0000_0022, 8'd1, 1'b1, 4'b0010);
        send_beat(64'h3000_0000_0000_0023, 8'd3, 1'b0, 4'b1000);
        check_eq("t2_port3", m_axis_tvalid, 4'b1000);
        send_beat(64'h3000_0000_0000_0024, 8'd3, 1'b1, 4'b1000);
        check_eq("t2_no_bubble", last_acc_cyc - a0, 3);
        s_idle();
        wait_cycles(2);

        // Out-of-range frame (tdest=7): consumed at full rate, one drop pulse, nothing emitted
        d0 = drop_cnt;
        send_beat(64'h7000_0000_0000_0031, 8'd7, 1'b0, 4'b0000);
        a0 = last_acc_cyc;
        check_eq("t3_novalid0", m_axis_tvalid, 4'b0000);
        send_beat(64'h7000_0000_0000_0032, 8'd0, 1'b0, 4'b0000);
        check_eq("t3_novalid1", m_axis_tvalid, 4'b0000);
        send_beat(64'h7000_0000_0000_0033, 8'd2, 1'b0, 4'b0000);
        check_eq("t3_novalid2", m_axis_tvalid, 4'b0000);
        send_beat(64'h7000_0000_0000_0034, 8'd7, 1'b1, 4'b0000);
        check_eq("t3_novalid3", m_axis_tvalid, 4'b0000);
        check_eq("t3_rate", last_acc_cyc - a0, 3);
        check_eq("t3_drop_pulses", drop_cnt - d0, 1);

        // Single-beat drop whose low bits alias port 0, then a single-beat frame to port 1
        d0 = drop_cnt;
        send_beat(64'h8400_0000_0000_0041, 8'h84, 1'b1, 4'b0000);
        a0 = last_acc_cyc;
        send_beat(64'h1000_0000_0000_0042, 8'd1, 1'b1, 4'b0010);
        check_eq("t3b_next_edge", last_acc_cyc - a0, 1);
        check_eq("t3b_port1", m_axis_tvalid, 4'b0010);
        check_eq("t3b_drop_pulses", drop_cnt - d0, 1);
        s_idle();
        wait_cycles(2);

        // Mid-frame tdest changes are ignored; tdest itself passes through
        send_beat(64'h2000_0000_0000_0051, 8'd2, 1'b0, 4'b0100);
        send_beat(64'h2000_0000_0000_0052, 8'd0, 1'b0, 4'b0100);
        check_eq("t4_sticky", m_axis_tvalid, 4'b0100);
        check_eq("t4_dest_pass", m_axis_tdest, 8'd0);
        send_beat(64'h2000_0000_0000_0053, 8'd0, 1'b1, 4'b0100);
        s_idle();
        wait_cycles(2);

        // Stall port 1 for 5 cycles: two beats held, input back-pressured, then drains
        m_axis_tready = 4'b1101;
        fork
            begin
                send_beat(64'h1000_0000_0000_0061, 8'd1, 1'b0, 4'b0010);
                send_beat(64'h1000_0000_0000_0062, 8'd1, 1'b0, 4'b0010);
                send_beat(64'h1000_0000_0000_0063, 8'd1, 1'b0, 4'b0010);
                send_beat(64'h1000_0000_0000_0064, 8'd1, 1'b1, 4'b0010);
                s_idle();
            end
            begin
                wait_cycles(5);
                check_eq("t5_buffered", exp_q.size(), 2);
                check_eq("t5_tready_low", s_axis_tready, 0);
                check_eq("t5_held_port1", m_axis_tvalid, 4'b0010);
                check_eq("t5_held_data", m_axis_tdata, 64'h1000_0000_0000_0061);
                m_axis_tready = 4'b1111;
            end
        join
        wait_cycles(4);
        check_eq("t5_drained", exp_q.size(), 0);

        // Reset in the middle of a stalled frame to port 3
        m_axis_tready = 4'b0111;
        send_beat(64'h3000_0000_0000_0071, 8'd3, 1'b0, 4'b1000);
        send_beat(64'h3000_0000_0000_0072, 8'd3, 1'b0, 4'b1000);
        s_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tvalid", m_axis_tvalid, 4'b0000);
        check_eq("t6_rst_tready", s_axis_tready, 0);
        check_eq("t6_rst_tdata", m_axis_tdata, 64'h0);
        exp_q.delete();
        m_axis_tready = 4'b1111;
        wait_cycles(2);
        rst_n = 1'b1;
        send_beat(64'h0000_0000_0000_0081, 8'd0, 1'b1, 4'b0001);
        check_eq("t6_port0", m_axis_tvalid, 4'b0001);
        s_idle();
        wait_cycles(3);
        check_eq("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
